// File: rtl/mips_pkg.sv
// Shared MIPS definitions: HI/LO func codes, multiply/divide FSM states and
// the conditional-negate helper used for sign handling.
package mips_pkg;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  // Wide enough for a 2*WIDTH product; callers cast the result back down.
  localparam int ABS_W = 128;

  function automatic logic [ABS_W-1:0] abs_val(input logic [ABS_W-1:0] v,
                                               input logic             neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle; WIDTH must be even, 4..64.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int W2 = 2 * WIDTH;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] opnd;
  logic             op_div, qneg, rneg;

  logic             is_mul, is_div, is_signed, rs_neg, rt_neg;
  logic [WIDTH-1:0] mag_rs, mag_rt;

  always_comb begin
    is_mul    = (func == F_MULT) || (func == F_MULTU);
    is_div    = (func == F_DIV)  || (func == F_DIVU);
    is_signed = (func == F_MULT) || (func == F_DIV);
    rs_neg    = is_signed & rs_val[WIDTH-1];
    rt_neg    = is_signed & rt_val[WIDTH-1];
    mag_rs    = WIDTH'(abs_val(ABS_W'(rs_val), rs_neg));
    mag_rt    = WIDTH'(abs_val(ABS_W'(rt_val), rt_neg));
  end

  // Shared adder: multiply adds the multiplicand to the upper half; divide
  // subtracts the divisor from the left-shifted remainder (carry-out = no borrow).
  logic [WIDTH:0]   add_a, add_b;
  logic             add_cin;
  logic [WIDTH+1:0] add_sum;
  logic [W2-1:0]    acc_nx;

  always_comb begin
    if (op_div) begin
      add_a   = acc[W2-1:WIDTH-1];
      add_b   = ~{1'b0, opnd};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, acc[W2-1:WIDTH]};
      add_b   = {1'b0, opnd};
      add_cin = 1'b0;
    end
    add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};
    if (op_div)
      acc_nx = add_sum[WIDTH+1] ? {add_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                                : {acc[W2-2:0], 1'b0};
    else
      acc_nx = acc[0] ? {add_sum[WIDTH:0], acc[WIDTH-1:1]}
                      : {1'b0, acc[W2-1:1]};
  end

  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo, rem, fix_hi, fix_lo;

  always_comb begin
    prod   = W2'(abs_val(ABS_W'(acc), qneg));
    quo    = WIDTH'(abs_val(ABS_W'(acc[WIDTH-1:0]), qneg));
    rem    = WIDTH'(abs_val(ABS_W'(acc[W2-1:WIDTH]), rneg));
    fix_hi = op_div ? rem : prod[W2-1:WIDTH];
    fix_lo = op_div ? quo : prod[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      op_div <= 1'b0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul || is_div) begin
              op_div <= is_div;
              // Divide-by-zero keeps the all-ones quotient unsigned-looking.
              qneg   <= (rs_neg ^ rt_neg) & ~(is_div & (rt_val == '0));
              rneg   <= rs_neg;
              acc    <= is_div ? {{WIDTH{1'b0}}, mag_rs} : {{WIDTH{1'b0}}, mag_rt};
              opnd   <= is_div ? mag_rt : mag_rs;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= RUN;
            end else if (func == F_MTHI) begin
              hi <= rs_val;
            end else if (func == F_MTLO) begin
              lo <= rs_val;
            end
          end
        end
        RUN: begin
          acc <= acc_nx;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit (WIDTH=32): reference results are queued
// at issue time and popped when done pulses.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic         clk = 1'b0;
  logic         rst_n, start, flush;
  logic [5:0]   func;
  logic [W-1:0] rs_val, rt_val;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .func  (func),
    .rs_val(rs_val),
    .rt_val(rt_val),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eh, output logic [W-1:0] el);
    longint p, q, r;
    logic [63:0] up;
    p = 0; q = 0; r = 0; up = '0;
    eh = '0; el = '0;
    case (f)
      F_MULT: begin
        p  = longint'($signed(a)) * longint'($signed(b));
        up = 64'(p);
        eh = up[63:32]; el = up[31:0];
      end
      F_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        eh = up[63:32]; el = up[31:0];
      end
      F_DIV: begin
        if (b == '0) begin
          el = '1; eh = a;
        end else begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          up = 64'(q); el = up[31:0];
          up = 64'(r); eh = up[31:0];
        end
      end
      F_DIVU: begin
        if (b == '0) begin
          el = '1; eh = a;
        end else begin
          el = a / b; eh = a % b;
        end
      end
      default: ;
    endcase
  endtask

  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit expect_result);
    exp_t e;
    if (expect_result) begin
      model(f, a, b, e.hi, e.lo);
      sb.push_back(e);
    end
    func = f; rs_val = a; rt_val = b; start = 1'b1;
    tick();
    start = 1'b0; func = '0;
  endtask

  // lat: ticks still expected until done is visible
  task automatic wait_result(input string name, input int lat);
    int   n = 0;
    exp_t e;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s busy_during_op: got %b want 1", name, busy);
    end
    while (done !== 1'b1 && n < 80) begin
      tick();
      n++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s timeout: done never seen after %0d cycles", name, n);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (n !== lat) begin
      n_bad++;
      $display("FAIL %s latency: got %0d want %0d", name, n, lat);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy_at_done: got %b want 0", name, busy);
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s scoreboard_empty: got done with no pending result", name);
      return;
    end
    e = sb.pop_front();
    if (hi !== e.hi || lo !== e.lo) begin
      n_bad++;
      $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; func = '0; rs_val = '0; rt_val = '0;
    tick(); tick();
    n_cmp++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b want all 0", hi, lo, busy, done);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    issue(F_MULT, 32'hFFFFFFFD, 32'd5, 1);
    wait_result("mult_neg3x5", W + 1);
    n_cmp++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
      n_bad++;
      $display("FAIL mult_neg3x5_const: got hi=%h lo=%h want hi=ffffffff lo=fffffff1", hi, lo);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL done_pulse_width: got %b want 0", done);
    end
    issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    wait_result("multu_max", W + 1);
    issue(F_MULT, 32'h80000000, 32'h80000000, 1);
    wait_result("mult_minxmin", W + 1);
  endtask

  task automatic test_div();
    issue(F_DIV, 32'hFFFFFFF9, 32'd2, 1);
    wait_result("div_neg7_2", W + 1);
    n_cmp++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      n_bad++;
      $display("FAIL div_neg7_2_const: got hi=%h lo=%h want hi=ffffffff lo=fffffffd", hi, lo);
    end
    issue(F_DIV, 32'h80000000, 32'hFFFFFFFF, 1);
    wait_result("div_overflow", W + 1);
    n_cmp++;
    if (hi !== 32'h0 || lo !== 32'h80000000) begin
      n_bad++;
      $display("FAIL div_overflow_const: got hi=%h lo=%h want hi=0 lo=80000000", hi, lo);
    end
    issue(F_DIV, 32'd100, 32'hFFFFFFF9, 1);
    wait_result("div_100_neg7", W + 1);
    issue(F_DIVU, 32'd7, 32'd0, 1);
    wait_result("divu_by_zero", W + 1);
    issue(F_DIV, 32'hFFFFFFFB, 32'd0, 1);
    wait_result("div_neg_by_zero", W + 1);
    n_cmp++;
    if (hi !== 32'hFFFFFFFB || lo !== 32'hFFFFFFFF) begin
      n_bad++;
      $display("FAIL div_neg_by_zero_const: got hi=%h lo=%h want hi=fffffffb lo=ffffffff", hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo();
    issue(F_MTHI, 32'h12345678, 32'h0, 0);
    n_cmp++;
    if (hi !== 32'h12345678 || done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mthi: got hi=%h done=%b busy=%b want hi=12345678 done=0 busy=0", hi, done, busy);
    end
    issue(F_MTLO, 32'h9ABCDEF0, 32'h0, 0);
    n_cmp++;
    if (lo !== 32'h9ABCDEF0 || hi !== 32'h12345678 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL mtlo: got hi=%h lo=%h done=%b want hi=12345678 lo=9abcdef0 done=0", hi, lo, done);
    end
    issue(6'b100000, 32'hFFFF0000, 32'h1, 0);
    n_cmp++;
    if (lo !== 32'h9ABCDEF0 || hi !== 32'h12345678 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL other_func_ignored: got hi=%h lo=%h busy=%b", hi, lo, busy);
    end
  endtask

  task automatic test_busy_ignore();
    logic [W-1:0] h0;
    int dones = 0;
    h0 = hi;
    issue(F_MULTU, 32'd1000, 32'd3000, 1);
    tick(); tick();
    issue(F_MTHI, 32'hDEADBEEF, 32'h0, 0);
    n_cmp++;
    if (hi !== h0) begin
      n_bad++;
      $display("FAIL mthi_while_busy: got hi=%h want %h", hi, h0);
    end
    issue(F_DIV, 32'd50, 32'd5, 0);
    wait_result("multu_with_ignored_starts", W + 1 - 4);
    for (int i = 0; i < W + 6; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++;
      $display("FAIL start_while_busy_no_extra_done: got %0d done pulses want 0", dones);
    end
  endtask

  task automatic test_flush();
    int dones = 0;
    issue(F_MTHI, 32'hA5A5A5A5, 32'h0, 0);
    issue(F_MTLO, 32'h5A5A5A5A, 32'h0, 0);
    issue(F_MULT, 32'd7, 32'd9, 0);
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_mid_run: got busy=%b done=%b want 0 0", busy, done);
    end
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones !== 0 || hi !== 32'hA5A5A5A5 || lo !== 32'h5A5A5A5A) begin
      n_bad++;
      $display("FAIL flush_no_write: got dones=%0d hi=%h lo=%h want 0 a5a5a5a5 5a5a5a5a", dones, hi, lo);
    end
    // flush while in FIX must suppress the write and done
    issue(F_DIVU, 32'd99, 32'd4, 0);
    for (int i = 0; i < W; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'hA5A5A5A5 || lo !== 32'h5A5A5A5A) begin
      n_bad++;
      $display("FAIL flush_in_fix: got done=%b busy=%b hi=%h lo=%h", done, busy, hi, lo);
    end
    // flush beats a simultaneous start
    func = F_MTHI; rs_val = 32'h11111111; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0; func = '0;
    n_cmp++;
    if (hi !== 32'hA5A5A5A5) begin
      n_bad++;
      $display("FAIL flush_over_start: got hi=%h want a5a5a5a5", hi);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    issue(F_DIV, 32'hFFFFFF9C, 32'd7, 0);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_div: got hi=%h lo=%h busy=%b done=%b want all 0", hi, lo, busy, done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones !== 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_discards_op: got dones=%0d busy=%b want 0 0", dones, busy);
    end
  endtask

  task automatic test_back_to_back();
    int c1;
    issue(F_DIVU, 32'd1000, 32'd7, 1);
    wait_result("divu_b2b_first", W + 1);
    c1 = cyc;
    issue(F_DIVU, 32'hFFFFFFFF, 32'd10, 1);
    wait_result("divu_b2b_second", W + 1);
    n_cmp++;
    if (cyc - c1 !== W + 2) begin
      n_bad++;
      $display("FAIL b2b_spacing: got %0d cycles want %0d", cyc - c1, W + 2);
    end
  endtask

  task automatic test_random();
    logic [5:0]   f;
    logic [W-1:0] a, b;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0: f = F_MULT;
        1: f = F_MULTU;
        2: f = F_DIV;
        default: f = F_DIVU;
      endcase
      a = $urandom();
      b = (i == 5) ? 32'h0 : ((i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom());
      if ($urandom_range(0, 1) == 1) b = -b;
      issue(f, a, b, 1);
      wait_result("random_op", W + 1);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_busy_ignore();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
